// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// The master side starts operations and the slave side produces results.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, borrow_out
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, borrow_out
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin: one bit per clock, LSB first, through a single full subtractor.
// Latency is WIDTH cycles from accept to the one-cycle done pulse.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_subtractor_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             br;
  logic [CW-1:0]    cnt;

  logic d_c;
  logic br_next_c;

  // Full subtractor on the current LSBs of the operand shift registers.
  assign d_c       = a_sr[0] ^ b_sr[0] ^ br;
  assign br_next_c = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      a_sr           <= '0;
      b_sr           <= '0;
      br             <= 1'b0;
      cnt            <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.diff       <= '0;
      bus.borrow_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sr     <= bus.a;
            b_sr     <= bus.b;
            br       <= bus.bin;
            bus.diff <= '0;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          // Result bits enter at the MSB so bit 0 lands in place after WIDTH shifts.
          a_sr     <= a_sr >> 1;
          b_sr     <= b_sr >> 1;
          br       <= br_next_c;
          bus.diff <= {d_c, bus.diff[WIDTH-1:1]};
          cnt      <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            bus.borrow_out <= br_next_c;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b1;
            state          <= DONE;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized and directed checks of serial_subtractor against an arithmetic reference model.
module tb_serial_subtractor;
  localparam int unsigned WIDTH = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(WIDTH)) bus ();
  serial_subtractor #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic, result reduced modulo 2^WIDTH.
  function automatic logic [WIDTH-1:0] ref_diff(input logic [WIDTH-1:0] a, b, input logic bin);
    int r;
    r = int'(a) - int'(b) - int'(bin);
    return WIDTH'(r);
  endfunction

  function automatic logic ref_borrow(input logic [WIDTH-1:0] a, b, input logic bin);
    return int'(a) < (int'(b) + int'(bin));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation; optionally pokes start plus new operands on RUN cycle 3.
  task automatic run_op(input logic [WIDTH-1:0] a, b, input logic bin,
                        input bit poke, input string tag);
    logic [WIDTH-1:0] ed;
    logic             eb;
    ed = ref_diff(a, b, bin);
    eb = ref_borrow(a, b, bin);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.bin   = bin;
    tick();
    bus.start = 1'b0;
    bus.a     = WIDTH'($urandom);
    bus.b     = WIDTH'($urandom);
    bus.bin   = 1'($urandom);
    for (int i = 0; i < int'(WIDTH); i++) begin
      check({tag, ".busy_run"}, 32'(bus.busy), 1);
      check({tag, ".done_run"}, 32'(bus.done), 0);
      if (poke && i == 2) begin
        bus.start = 1'b1;
        bus.a     = 8'hAA;
        bus.b     = 8'h55;
      end else begin
        bus.start = 1'b0;
      end
      tick();
    end
    check({tag, ".done"},   32'(bus.done),       1);
    check({tag, ".busy_d"}, 32'(bus.busy),       0);
    check({tag, ".diff"},   32'(bus.diff),       32'(ed));
    check({tag, ".borrow"}, 32'(bus.borrow_out), 32'(eb));
    tick();
    check({tag, ".done_off"},    32'(bus.done),       0);
    check({tag, ".busy_idle"},   32'(bus.busy),       0);
    check({tag, ".diff_hold"},   32'(bus.diff),       32'(ed));
    check({tag, ".borrow_hold"}, 32'(bus.borrow_out), 32'(eb));
  endtask

  initial begin
    int done_cyc[$];
    bit prev_done;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.bin   = 1'b0;

    tick();
    check("rst.busy",   32'(bus.busy),       0);
    check("rst.done",   32'(bus.done),       0);
    check("rst.diff",   32'(bus.diff),       0);
    check("rst.borrow", 32'(bus.borrow_out), 0);
    rst_n = 1'b1;

    // Directed cases; the first accept happens on the first edge after release.
    run_op(8'h05, 8'h03, 1'b0, 1'b0, "d_5m3");
    run_op(8'h03, 8'h05, 1'b0, 1'b0, "d_3m5");
    run_op(8'hFF, 8'h00, 1'b0, 1'b0, "d_ffm0");
    run_op(8'h10, 8'h01, 1'b0, 1'b1, "d_poke");
    tick();
    check("poke.ignored", 32'(bus.busy), 0);
    run_op(8'h00, 8'h00, 1'b1, 1'b0, "d_0m0b");

    // Reset during RUN cycle 4 clears outputs at once; no done pulse follows.
    bus.start = 1'b1;
    bus.a     = 8'h77;
    bus.b     = 8'h12;
    bus.bin   = 1'b0;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst.busy",   32'(bus.busy),       0);
    check("mid_rst.done",   32'(bus.done),       0);
    check("mid_rst.diff",   32'(bus.diff),       0);
    check("mid_rst.borrow", 32'(bus.borrow_out), 0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      check("mid_rst.no_done", 32'(bus.done), 0);
    end
    run_op(8'h9C, 8'h3D, 1'b1, 1'b0, "post_rst");

    // start held high: accepts every WIDTH+2 edges, single-cycle done pulses.
    bus.a     = 8'h20;
    bus.b     = 8'h07;
    bus.bin   = 1'b1;
    bus.start = 1'b1;
    prev_done = 1'b0;
    for (int c = 0; c < 45; c++) begin
      tick();
      check("held.pulse_width", 32'(prev_done & bus.done), 0);
      if (bus.done) begin
        done_cyc.push_back(c);
        check("held.diff",   32'(bus.diff),       32'(ref_diff(8'h20, 8'h07, 1'b1)));
        check("held.borrow", 32'(bus.borrow_out), 32'(ref_borrow(8'h20, 8'h07, 1'b1)));
      end
      prev_done = bus.done;
    end
    bus.start = 1'b0;
    check("held.count", 32'(done_cyc.size()), 4);
    foreach (done_cyc[i]) check("held.spacing", 32'(done_cyc[i]), 32'(int'(WIDTH) + 10 * i));
    repeat (12) tick();
    check("held.drained", 32'(bus.busy), 0);

    for (int n = 0; n < 30; n++) begin
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom_range(0, 1)), "rand");
    end
    run_op(8'h00, 8'hFF, 1'b1, 1'b0, "edge_min");
    run_op(8'hFF, 8'hFF, 1'b0, 1'b0, "edge_eq");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
